// File: rtl/gemm_pkg.sv
// Shared GEMM definitions: controller state encoding and drain-length helper.
// Used by gemm_skew_feeder and by gemm_arr's controller so both agree on the
// state encoding and on how long the skew pipeline takes to flush.
package gemm_pkg;

  // Job controller states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } gemm_state_e;

  // Number of zero-fill cycles needed to flush the skew registers
  // through a ROWS x COLS array.
  function automatic int unsigned drain_len(input int unsigned rows,
                                            input int unsigned cols);
    return rows + cols - 1;
  endfunction

endpackage

// File: rtl/gemm_skew_lane.sv
// One skew lane: a DEPTH-stage shift register that advances only when
// enabled. A synchronous clear empties it at job start so no data from a
// previous job can leak into the array.
module gemm_skew_lane #(
  parameter int DEPTH      = 1,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clr,
  input  logic                  i_en,
  input  logic [DATA_WIDTH-1:0] i_din,
  output logic [DATA_WIDTH-1:0] o_dout
);

  logic [DATA_WIDTH-1:0] stage_q [DEPTH];

  // Shift one slot per enabled cycle; reset or job-start clear zeroes every slot.
  // NOTE: these stages are plain flops rather than a RAM, so every slot can be
  // cleared in a single cycle like any other state register.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else if (i_en) begin
      stage_q[0] <= i_din;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign o_dout = stage_q[DEPTH-1];

endmodule

// File: rtl/gemm_skew_feeder.sv
// GEMM skew feeder: accepts one x column vector and one w row vector per
// k-beat and presents them to a systolic array with lane r (c) delayed by
// r+1 (c+1) advance cycles, then flushes the skew with zeros.
// Optional feature: define GEMM_FEEDER_ERR_EN to add the sticky o_err
// protocol-violation flag.
module gemm_skew_feeder
  import gemm_pkg::*;
#(
  parameter int ROWS       = 2,
  parameter int COLS       = 2,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic [LEN_WIDTH-1:0]       i_len,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [ROWS*DATA_WIDTH-1:0] i_vec_x,
  input  logic [COLS*DATA_WIDTH-1:0] i_vec_w,
  output logic [ROWS*DATA_WIDTH-1:0] o_data_x,
  output logic [COLS*DATA_WIDTH-1:0] o_data_w,
  output logic                       o_valid,
  output logic                       o_acc_clr,
  output logic                       o_busy,
`ifdef GEMM_FEEDER_ERR_EN
  output logic                       o_err,
`endif
  output logic                       o_done
);

  localparam int unsigned DRAIN_LEN = drain_len(ROWS, COLS);
  localparam int          DCW       = $clog2(DRAIN_LEN + 1);

  gemm_state_e          state_q, state_d;
  logic [LEN_WIDTH-1:0] beat_cnt_q;
  logic [DCW-1:0]       drain_cnt_q;

  logic in_stream;
  logic in_drain;
  logic beat_acc;
  logic last_beat;
  logic drain_last;
  logic job_start;
  logic s_en;

  assign in_stream  = (state_q == ST_STREAM);
  assign in_drain   = (state_q == ST_DRAIN);
  assign beat_acc   = in_stream && i_valid;
  assign last_beat  = beat_acc && (beat_cnt_q == LEN_WIDTH'(1));
  assign drain_last = in_drain && (drain_cnt_q == DCW'(1));
  // Any start seen in IDLE clears the skew lanes, including zero-length jobs.
  assign job_start  = (state_q == ST_IDLE) && i_start;
  // Lanes advance on each accepted beat and on every flush cycle.
  assign s_en       = beat_acc || in_drain;

  // Next-state and state-decoded outputs.
  always_comb begin
    state_d = state_q;
    o_ready = 1'b0;
    o_busy  = 1'b0;
    o_done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) state_d = (i_len != '0) ? ST_STREAM : ST_DONE;
      end
      ST_STREAM: begin
        o_ready = 1'b1;
        o_busy  = 1'b1;
        if (last_beat) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        o_busy = 1'b1;
        if (drain_last) state_d = ST_DONE;
      end
      ST_DONE: begin
        o_busy  = 1'b1;
        o_done  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register, beat/drain counters and registered strobes.
  // NOTE: non-blocking assignments here so every flop samples the pre-edge
  // values of its peers, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      beat_cnt_q  <= '0;
      drain_cnt_q <= '0;
      o_valid     <= 1'b0;
      o_acc_clr   <= 1'b0;
    end else begin
      state_q   <= state_d;
      o_valid   <= s_en;
      o_acc_clr <= job_start && (i_len != '0);

      if (job_start) beat_cnt_q <= i_len;
      else if (beat_acc) beat_cnt_q <= beat_cnt_q - LEN_WIDTH'(1);

      if (last_beat) drain_cnt_q <= DCW'(DRAIN_LEN);
      else if (in_drain) drain_cnt_q <= drain_cnt_q - DCW'(1);
    end
  end

  // x lanes: lane r is r+1 stages deep; zeros are pushed during the flush.
  for (genvar r = 0; r < ROWS; r++) begin : g_x_lane
    logic [DATA_WIDTH-1:0] din;
    assign din = in_drain ? '0 : i_vec_x[(ROWS-r)*DATA_WIDTH-1 -: DATA_WIDTH];

    gemm_skew_lane #(
      .DEPTH      (r + 1),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_lane (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_clr  (job_start),
      .i_en   (s_en),
      .i_din  (din),
      .o_dout (o_data_x[(ROWS-r)*DATA_WIDTH-1 -: DATA_WIDTH])
    );
  end

  // w lanes: lane c is c+1 stages deep; zeros are pushed during the flush.
  for (genvar c = 0; c < COLS; c++) begin : g_w_lane
    logic [DATA_WIDTH-1:0] din;
    assign din = in_drain ? '0 : i_vec_w[(COLS-c)*DATA_WIDTH-1 -: DATA_WIDTH];

    gemm_skew_lane #(
      .DEPTH      (c + 1),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_lane (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_clr  (job_start),
      .i_en   (s_en),
      .i_din  (din),
      .o_dout (o_data_w[(COLS-c)*DATA_WIDTH-1 -: DATA_WIDTH])
    );
  end

`ifdef GEMM_FEEDER_ERR_EN
  // Sticky flag for beats offered outside STREAM or starts outside IDLE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_err <= 1'b0;
    end else if ((i_valid && !in_stream) || (i_start && (state_q != ST_IDLE))) begin
      o_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_gemm_skew_feeder.sv
// Self-checking bench for gemm_skew_feeder (ROWS=COLS=2, 16-bit data).
// A cycle table covers the reference job and a zero-length job; random jobs
// with stalls are checked against a model that derives every o_valid beat
// from the accepted beat list.
module tb_gemm_skew_feeder;

  localparam int ROWS = 2;
  localparam int COLS = 2;
  localparam int DW   = 16;
  localparam int LW   = 16;
  localparam int XW   = ROWS * DW;
  localparam int WW   = COLS * DW;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_start;
  logic [LW-1:0] i_len;
  logic          i_valid;
  logic          o_ready;
  logic [XW-1:0] i_vec_x;
  logic [WW-1:0] i_vec_w;
  logic [XW-1:0] o_data_x;
  logic [WW-1:0] o_data_w;
  logic          o_valid;
  logic          o_acc_clr;
  logic          o_busy;
  logic          o_done;
`ifdef GEMM_FEEDER_ERR_EN
  logic          o_err;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  logic [XW-1:0] mx[$];
  logic [WW-1:0] mw[$];

  gemm_skew_feeder #(
    .ROWS       (ROWS),
    .COLS       (COLS),
    .DATA_WIDTH (DW),
    .LEN_WIDTH  (LW)
  ) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_start   (i_start),
    .i_len     (i_len),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_vec_x   (i_vec_x),
    .i_vec_w   (i_vec_w),
    .o_data_x  (o_data_x),
    .o_data_w  (o_data_w),
    .o_valid   (o_valid),
    .o_acc_clr (o_acc_clr),
    .o_busy    (o_busy),
`ifdef GEMM_FEEDER_ERR_EN
    .o_err     (o_err),
`endif
    .o_done    (o_done)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic          start;
    logic [LW-1:0] len;
    logic          valid;
    logic [XW-1:0] x;
    logic [WW-1:0] w;
    logic [4:0]    ctrl;  // {ready, valid, acc_clr, busy, done}
    logic [XW-1:0] ex;
    logic [WW-1:0] ew;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pk(input int a, input int b);
    return {a[15:0], b[15:0]};
  endfunction

  function automatic vec_t mk(input logic s, input int len, input logic v,
                              input logic [XW-1:0] x, input logic [WW-1:0] w,
                              input logic [4:0] c, input logic [XW-1:0] ex,
                              input logic [WW-1:0] ew);
    vec_t t;
    t.start = s; t.len = LW'(len); t.valid = v; t.x = x; t.w = w;
    t.ctrl = c; t.ex = ex; t.ew = ew;
    return t;
  endfunction

  // Model: the j-th o_valid cycle shows beat j-r on lane r, zero outside the job.
  function automatic logic [XW-1:0] exp_x(input int j, input int len);
    logic [XW-1:0] v, src;
    v = '0;
    for (int r = 0; r < ROWS; r++) begin
      int k;
      k = j - r;
      if (k >= 0 && k < len) begin
        src = mx[k];
        v[(ROWS-r)*DW-1 -: DW] = src[(ROWS-r)*DW-1 -: DW];
      end
    end
    return v;
  endfunction

  function automatic logic [WW-1:0] exp_w(input int j, input int len);
    logic [WW-1:0] v, src;
    v = '0;
    for (int c = 0; c < COLS; c++) begin
      int k;
      k = j - c;
      if (k >= 0 && k < len) begin
        src = mw[k];
        v[(COLS-c)*DW-1 -: DW] = src[(COLS-c)*DW-1 -: DW];
      end
    end
    return v;
  endfunction

  task automatic fill_fixed();
    mx.delete(); mw.delete();
    mx.push_back(pk(1, 2));   mw.push_back(pk(10, 20));
    mx.push_back(pk(3, 4));   mw.push_back(pk(30, 40));
    mx.push_back(pk(5, 6));   mw.push_back(pk(50, 60));
  endtask

  task automatic fill_random(input int len);
    mx.delete(); mw.delete();
    for (int i = 0; i < len; i++) begin
      mx.push_back(XW'($urandom));
      mw.push_back(WW'($urandom));
    end
  endtask

  task automatic do_reset();
    i_rst = 1'b1; i_start = 1'b0; i_valid = 1'b0; i_len = '0;
    i_vec_x = '0; i_vec_w = '0;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ctrl"}, {o_ready, o_valid, o_acc_clr, o_busy, o_done}, 5'b00000);
    check({tag, "_x"}, o_data_x, '0);
    check({tag, "_w"}, o_data_w, '0);
  endtask

  // Runs one job on the beats in mx/mw with random stalls; noisy jobs also
  // raise i_start mid-job and offer beats while not ready.
  task automatic run_job(input int len, input int stall_pct, input bit noisy);
    int            accepted, cyc, budget, acc_pulses;
    bit            first, exp_ready, timed_out;
    logic [XW-1:0] obs_x[$];
    logic [WW-1:0] obs_w[$];
    logic [XW-1:0] prev_x;
    logic [WW-1:0] prev_w;
    int            n_exp;

    i_start = 1'b1; i_len = LW'(len); i_valid = 1'b0;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    check("start_clears_x", o_data_x, '0);
    check("start_clears_w", o_data_w, '0);

    accepted = 0; cyc = 0; acc_pulses = 0; first = 1'b1; timed_out = 1'b0;
    budget = len * 30 + 40;
    prev_x = '0; prev_w = '0;
    while (1) begin
      if (o_valid) begin
        obs_x.push_back(o_data_x);
        obs_w.push_back(o_data_w);
      end else if (!first) begin
        check("hold_x", o_data_x, prev_x);
        check("hold_w", o_data_w, prev_w);
      end
      prev_x = o_data_x; prev_w = o_data_w; first = 1'b0;
      acc_pulses += int'(o_acc_clr);
      exp_ready = (accepted < len);
      check("ready", o_ready, exp_ready);
      check("busy", o_busy, 1);
      if (o_done) break;
      if (cyc >= budget) begin
        check("done_timeout", 0, 1);
        timed_out = 1'b1;
        break;
      end
      cyc++;
      i_vec_x = XW'($urandom); i_vec_w = WW'($urandom);
      i_valid = 1'b0;
      if (exp_ready) begin
        if ($urandom_range(99) >= stall_pct) begin
          i_valid = 1'b1; i_vec_x = mx[accepted]; i_vec_w = mw[accepted];
          accepted++;
        end
      end else if (noisy) begin
        i_valid = 1'($urandom_range(1));
      end
      i_start = noisy && (cyc == 1 || $urandom_range(3) == 0);
      i_len   = noisy ? LW'($urandom_range(1, 9)) : LW'(len);
      @(posedge i_clk); #1;
    end

    i_start = 1'b0; i_valid = 1'b0;
    @(posedge i_clk); #1;
    if (!timed_out) begin
      check("post_done_ctrl", {o_ready, o_valid, o_acc_clr, o_busy, o_done}, 5'b00000);
      n_exp = (len > 0) ? len + ROWS + COLS - 1 : 0;
      check("n_valid_cycles", obs_x.size(), n_exp);
      check("acc_clr_pulses", acc_pulses, (len > 0) ? 1 : 0);
      for (int j = 0; j < obs_x.size() && j < n_exp; j++) begin
        check($sformatf("data_x[%0d]", j), obs_x[j], exp_x(j, len));
        check($sformatf("data_w[%0d]", j), obs_w[j], exp_w(j, len));
      end
    end
  endtask

  vec_t vt[10];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = mk(1, 3, 0, '0,        '0,          5'b10110, '0,        '0);
    vt[1] = mk(0, 0, 1, pk(1, 2),  pk(10, 20),  5'b11010, pk(1, 0),  pk(10, 0));
    vt[2] = mk(0, 0, 1, pk(3, 4),  pk(30, 40),  5'b11010, pk(3, 2),  pk(30, 20));
    vt[3] = mk(0, 0, 1, pk(5, 6),  pk(50, 60),  5'b01010, pk(5, 4),  pk(50, 40));
    vt[4] = mk(0, 0, 1, pk(7, 7),  pk(7, 7),    5'b01010, pk(0, 6),  pk(0, 60));
    vt[5] = mk(0, 0, 0, '0,        '0,          5'b01010, '0,        '0);
    vt[6] = mk(0, 0, 0, '0,        '0,          5'b01011, '0,        '0);
    vt[7] = mk(0, 0, 1, pk(9, 9),  pk(9, 9),    5'b00000, '0,        '0);
    vt[8] = mk(1, 0, 0, '0,        '0,          5'b00011, '0,        '0);
    vt[9] = mk(0, 0, 0, '0,        '0,          5'b00000, '0,        '0);

    do_reset();
    do_reset();
    check_idle("reset");

    // Reference job followed by a zero-length job, cycle by cycle.
    for (int i = 0; i < 10; i++) begin
      i_start = vt[i].start; i_len = vt[i].len; i_valid = vt[i].valid;
      i_vec_x = vt[i].x; i_vec_w = vt[i].w;
      @(posedge i_clk); #1;
      check($sformatf("tbl%0d_ctrl", i), {o_ready, o_valid, o_acc_clr, o_busy, o_done}, vt[i].ctrl);
      check($sformatf("tbl%0d_x", i), o_data_x, vt[i].ex);
      check($sformatf("tbl%0d_w", i), o_data_w, vt[i].ew);
    end
    i_start = 1'b0; i_valid = 1'b0;

    // Reset in the middle of DRAIN, then the reference job again.
    fill_fixed();
    i_start = 1'b1; i_len = 3;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      i_valid = 1'b1; i_vec_x = mx[i]; i_vec_w = mw[i];
      @(posedge i_clk); #1;
    end
    i_valid = 1'b0;
    @(posedge i_clk); #1;
    check("mid_drain_busy", o_busy, 1);
    do_reset();
    check_idle("drain_reset");
    run_job(3, 0, 0);

    // Reference job with stalls, a zero-length job, then a noisy job.
    run_job(3, 50, 0);
    run_job(0, 0, 0);
    fill_random(4);
    run_job(4, 20, 1);

    // Back-to-back random jobs.
    for (int n = 0; n < 20; n++) begin
      int len;
      len = $urandom_range(1, 8);
      fill_random(len);
      run_job(len, 30, 0);
    end

`ifdef GEMM_FEEDER_ERR_EN
    do_reset();
    check("err_after_reset", o_err, 0);
    fill_random(4);
    run_job(4, 0, 1);
    check("err_set", o_err, 1);
    fill_random(2);
    run_job(2, 0, 0);
    check("err_sticky", o_err, 1);
    do_reset();
    check("err_cleared", o_err, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
